// File: rtl/axis_result_fifo.sv
// First-word-fall-through AXI-Stream result FIFO behind the FP pipeline.
// Exposes the occupancy level and almost_full so the issue logic can throttle.
module axis_result_fifo #(
  parameter int SIZE        = 64,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [SIZE-1:0]          s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [SIZE-1:0]          m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            wr_fire;
  logic            rd_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready comes only from registered pointers, so a stalled consumer never
  // reaches the pipeline combinationally.
  assign s_axis_tready = !full && aresetn;
  assign m_axis_tvalid = !empty && aresetn;
  assign m_axis_tdata  = mem[rd_ptr[AW-1:0]];

  assign wr_fire = s_axis_tvalid && s_axis_tready;
  assign rd_fire = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is intentionally left uncleared on reset.
  always_ff @(posedge aclk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  assign almost_full = (level >= PW'(AFULL_LEVEL));

endmodule
